// File: rtl/hilo_div_unit.sv
// hilo_div_unit
// Multi-cycle integer divider with architectural HI/LO registers, serving
// DIV/DIVU/MFHI/MFLO/MTHI/MTLO in the execute stage of the MIPS core.
// A restoring divider runs on operand magnitudes (one quotient bit per edge),
// then a single fix-up cycle applies the sign correction and writes HI/LO.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        launch a divide (ignored while busy or when flush is high)
//   is_signed    1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend     rs operand, sampled with start
//   divisor      rt operand, sampled with start
//   flush        pipeline flush; aborts an in-flight divide without writing
//   hi_we/lo_we  MTHI/MTLO write enables, honoured only while idle
//   wdata        MTHI/MTLO write data
//   busy         divide in progress
//   done         one-cycle pulse when a divide writes HI/LO
//   div_by_zero  set by a completed divide-by-zero, cleared by any other
//   hi           HI register (remainder)
//   lo           LO register (quotient)
module hilo_div_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  // Two's complement negate when neg is set. WIDTH-bit wraparound is
  // intentional: the most negative value maps onto itself, which is its
  // correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
    return neg ? (~v + ONE) : v;
  endfunction

  // Control state (reset)
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Datapath state (no reset; only meaningful while busy)
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvnd_q, dvnd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;

  logic             signed_mode;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  assign signed_mode = is_signed & SIGNED_EN;

  // Restoring step: bring the next dividend bit into the partial remainder
  // and try the subtraction; bit WIDTH of diff is the borrow.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvsr_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    dvnd_d    = dvnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;

    unique case (state_q)
      IDLE: begin
        // MT writes share the edge with an accepted start; the later
        // divide result overwrites them.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          dvnd_d    = dividend;
          dvsr_d    = cond_negate(divisor,  signed_mode & divisor[WIDTH-1]);
          quo_d     = cond_negate(dividend, signed_mode & dividend[WIDTH-1]);
          rem_d     = '0;
          neg_quo_d = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = signed_mode & dividend[WIDTH-1];
          zero_d    = (divisor == '0);
          cnt_d     = CNT_W'(WIDTH - 1);
          state_d   = (divisor == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (zero_q) begin
            lo_d = '1;
            hi_d = dvnd_q;
            dz_d = 1'b1;
          end else begin
            lo_d = cond_negate(quo_q, neg_quo_q);
            hi_d = cond_negate(rem_q, neg_rem_q);
            dz_d = 1'b0;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvsr_q    <= dvsr_d;
    dvnd_q    <= dvnd_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    zero_q    <= zero_d;
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
